// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-master serial-bus arbiter.
// Imported by the interface, the round-robin picker and the arbiter top.
package bus_pkg;

    localparam int unsigned DefSselBits = 2;
    localparam int unsigned DefNslaves  = 3;
    localparam int unsigned DefTimeout  = 16;

    localparam logic Master0 = 1'b0;
    localparam logic Master1 = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StAddr,
        StXfer,
        StWaitRdy,
        StRelease
    } bus_state_e;

    function automatic logic [1:0] master_onehot(input logic idx);
        return (idx == Master1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter-side bundle of the shared serial bus: requests, post-mux bus lines,
// slave handshakes and the arbiter's grant/routing outputs.
interface bus_arbiter_if #(
    parameter int unsigned SSEL_BITS = bus_pkg::DefSselBits,
    parameter int unsigned NSLAVES   = bus_pkg::DefNslaves
) ();

    logic [1:0]           req;
    logic                 bus_valid;
    logic                 bus_addr;
    logic [NSLAVES-1:0]   slave_ready;
    logic [1:0]           grant;
    logic                 mselect;
    logic [SSEL_BITS-1:0] sselect;
    logic [NSLAVES-1:0]   svalid;
    logic                 BusAvailable;
    logic                 err;

    // The arbiter owns the bus, so it takes the master view.
    modport master (
        input  req,
        input  bus_valid,
        input  bus_addr,
        input  slave_ready,
        output grant,
        output mselect,
        output sselect,
        output svalid,
        output BusAvailable,
        output err
    );

    modport slave (
        output req,
        output bus_valid,
        output bus_addr,
        output slave_ready,
        input  grant,
        input  mselect,
        input  sselect,
        input  svalid,
        input  BusAvailable,
        input  err
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational two-way round-robin selector: a lone requester wins outright,
// a tie goes to the master that was not granted last.
module arb_rr_pick
    import bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);

    always_comb begin
        pick = Master0;
        unique case (req)
            2'b01:   pick = Master0;
            2'b10:   pick = Master1;
            2'b11:   pick = ~last;
            default: pick = Master0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, multi-slave serial-bus arbiter: round-robin grant, serial slave-select
// decode, validIn routing and grant hold until the addressed slave is ready.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned SSEL_BITS = DefSselBits,
    parameter int unsigned NSLAVES   = DefNslaves,
    parameter int unsigned TIMEOUT   = DefTimeout
) (
    input logic           clk,
    input logic           reset,
    bus_arbiter_if.master bus
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BitW = $clog2(SSEL_BITS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(SSEL_BITS - 1);

    bus_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [SSEL_BITS-1:0] shift_q, shift_d;
    logic [BitW-1:0]      nbits_q, nbits_d;
    logic                 bad_q, bad_d;
    logic                 last_q, last_d;
    logic [1:0]           grant_q, grant_d;
    logic                 mselect_q, mselect_d;
    logic [SSEL_BITS-1:0] sselect_q, sselect_d;
    logic [NSLAVES-1:0]   svalid_q, svalid_d;
    logic                 avail_q, avail_d;
    logic                 err_q, err_d;

    logic                 pick;
    logic                 sel_ready;
    logic                 req_held;
    logic [SSEL_BITS-1:0] shift_in;

    arb_rr_pick u_pick (
        .req  (bus.req),
        .last (last_q),
        .pick (pick)
    );

    // Select bits arrive MSB first.
    assign shift_in = (shift_q << 1) | SSEL_BITS'(bus.bus_addr);
    assign req_held = (bus.req & grant_q) != 2'b00;

    always_comb begin
        sel_ready = 1'b0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (sselect_q == SSEL_BITS'(i)) begin
                sel_ready = bus.slave_ready[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        nbits_d   = nbits_q;
        bad_d     = bad_q;
        last_d    = last_q;
        grant_d   = grant_q;
        mselect_d = mselect_q;
        sselect_d = sselect_q;
        svalid_d  = '0;
        avail_d   = avail_q;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req != 2'b00) begin
                    grant_d   = master_onehot(pick);
                    mselect_d = pick;
                    avail_d   = 1'b0;
                    cnt_d     = '0;
                    bad_d     = 1'b0;
                    state_d   = StGrant;
                end
            end

            StGrant: begin
                if (bus.bus_valid) begin
                    shift_d = SSEL_BITS'(bus.bus_addr);
                    nbits_d = BitW'(1);
                    state_d = StAddr;
                end else if (!req_held) begin
                    state_d = StRelease;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StAddr: begin
                // A low bus_valid just stalls the shift.
                if (bus.bus_valid) begin
                    shift_d = shift_in;
                    nbits_d = nbits_q + 1'b1;
                    if (nbits_q == BitLast) begin
                        sselect_d = shift_in;
                        state_d   = StXfer;
                        if (32'(shift_in) >= NSLAVES) begin
                            bad_d = 1'b1;
                            err_d = 1'b1;
                        end
                    end
                end
            end

            StXfer: begin
                if (bus.bus_valid) begin
                    for (int unsigned i = 0; i < NSLAVES; i++) begin
                        svalid_d[i] = !bad_q && (sselect_q == SSEL_BITS'(i));
                    end
                end else begin
                    state_d = bad_q ? StRelease : StWaitRdy;
                end
            end

            StWaitRdy: begin
                if (sel_ready) begin
                    state_d = StRelease;
                end
            end

            StRelease: begin
                grant_d = 2'b00;
                last_d  = mselect_q;
                avail_d = 1'b1;
                bad_d   = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            nbits_q   <= '0;
            bad_q     <= 1'b0;
            last_q    <= Master1;
            grant_q   <= 2'b00;
            mselect_q <= Master0;
            sselect_q <= '0;
            svalid_q  <= '0;
            avail_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            nbits_q   <= nbits_d;
            bad_q     <= bad_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            mselect_q <= mselect_d;
            sselect_q <= sselect_d;
            svalid_q  <= svalid_d;
            avail_q   <= avail_d;
            err_q     <= err_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.mselect      = mselect_q;
    assign bus.sselect      = sselect_q;
    assign bus.svalid       = svalid_q;
    assign bus.BusAvailable = avail_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected select/routing results are queued when a
// transaction is driven and compared when the arbiter latches the select.
module tb_bus_arbiter;

    localparam int unsigned Timeout = 16;

    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] sv;
        logic       err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb[$];

    bus_arbiter_if bif ();

    bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in GRANT at a falling edge; ends in IDLE at a falling edge.
    task automatic xfer(input logic [1:0] gnt, input logic [1:0] sel, input int beats,
                        input int rdy_delay, input bit noise);
        exp_t e;
        e.sel = sel;
        e.err = (sel > 2'd2);
        e.sv  = e.err ? 3'b000 : (3'b001 << sel);
        sb.push_back(e);

        bif.bus_valid = 1'b1;
        bif.bus_addr  = sel[1];
        tick();
        check("addr_grant_hold", bif.grant, gnt);
        check("addr_busy", bif.BusAvailable, 1'b0);
        bif.bus_addr = sel[0];
        tick();
        e = sb.pop_front();
        check("sselect", bif.sselect, e.sel);
        check("select_err", bif.err, e.err);
        check("svalid_before_data", bif.svalid, 3'b000);
        for (int b = 0; b < beats; b++) begin
            bif.bus_addr = 1'($urandom_range(0, 1));
            tick();
            check("svalid_beat", bif.svalid, e.sv);
            check("err_one_shot", bif.err, 1'b0);
        end
        bif.bus_valid = 1'b0;
        tick();
        check("svalid_fall", bif.svalid, 3'b000);
        check("grant_after_fall", bif.grant, gnt);
        if (!e.err) begin
            for (int d = 0; d < rdy_delay; d++) begin
                bif.slave_ready = noise ? 3'b001 : 3'b000;
                tick();
                check("wait_grant_hold", bif.grant, gnt);
            end
            bif.slave_ready = e.sv;
            tick();
            check("release_grant_hold", bif.grant, gnt);
            bif.slave_ready = 3'b000;
        end
        tick();
        check("release_grant", bif.grant, 2'b00);
        check("release_avail", bif.BusAvailable, 1'b1);
    endtask

    initial begin
        int  n;
        bit  seen;
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        bif.req         = 2'b00;
        bif.bus_valid   = 1'b0;
        bif.bus_addr    = 1'b0;
        bif.slave_ready = 3'b000;
        tick();
        tick();
        check("rst_grant", bif.grant, 2'b00);
        check("rst_mselect", bif.mselect, 1'b0);
        check("rst_sselect", bif.sselect, 2'b00);
        check("rst_svalid", bif.svalid, 3'b000);
        check("rst_err", bif.err, 1'b0);
        check("rst_avail", bif.BusAvailable, 1'b1);
        reset = 1'b1;
        tick();
        check("idle_grant", bif.grant, 2'b00);
        check("idle_avail", bif.BusAvailable, 1'b1);

        // Single request, then a tie while master 0 holds the bus.
        bif.req = 2'b01;
        tick();
        check("req01_grant", bif.grant, 2'b01);
        check("req01_mselect", bif.mselect, 1'b0);
        bif.req = 2'b11;
        xfer(2'b01, 2'b01, 3, 3, 1'b0);

        tick();
        check("rr_grant_m1", bif.grant, 2'b10);
        check("rr_mselect_m1", bif.mselect, 1'b1);
        xfer(2'b10, 2'b10, 2, 2, 1'b1);

        tick();
        check("rr_grant_back_m0", bif.grant, 2'b01);
        bif.req = 2'b01;
        xfer(2'b01, 2'b11, 2, 0, 1'b0);

        // Ready already high on the first WAIT_RDY cycle.
        tick();
        check("m0_regrant", bif.grant, 2'b01);
        xfer(2'b01, 2'b00, 1, 0, 1'b0);

        // Timeout with bus_valid held low.
        tick();
        check("to_grant", bif.grant, 2'b01);
        n    = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            tick();
            n++;
            if (bif.err === 1'b1) seen = 1'b1;
        end
        check("to_err_seen", seen, 1'b1);
        check("to_err_cycle", n, Timeout);
        bif.req = 2'b00;
        tick();
        check("to_err_one_shot", bif.err, 1'b0);
        tick();
        check("to_grant_clear", bif.grant, 2'b00);
        check("to_avail", bif.BusAvailable, 1'b1);

        // Asynchronous reset in the middle of a transfer.
        bif.req = 2'b10;
        tick();
        check("mid_grant", bif.grant, 2'b10);
        bif.bus_valid = 1'b1;
        bif.bus_addr  = 1'b0;
        tick();
        bif.bus_addr = 1'b1;
        tick();
        tick();
        check("mid_svalid", bif.svalid, 3'b010);
        check("mid_sselect", bif.sselect, 2'b01);
        reset = 1'b0;
        #1;
        check("async_grant", bif.grant, 2'b00);
        check("async_svalid", bif.svalid, 3'b000);
        check("async_sselect", bif.sselect, 2'b00);
        check("async_mselect", bif.mselect, 1'b0);
        check("async_avail", bif.BusAvailable, 1'b1);
        bif.bus_valid = 1'b0;
        bif.req       = 2'b11;
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_grant", bif.grant, 2'b01);
        check("post_rst_mselect", bif.mselect, 1'b0);
        bif.req = 2'b00;
        tick();
        tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
